// File: rtl/multi_pit_if.sv
// Register-write, interrupt-acknowledge and readback bus of the multi-channel PIT.
// The master drives writes, acks and the readback select; the timer is the slave.
interface multi_pit_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              wr_en;
   logic [1:0]        wr_sel;
   logic [CH_W-1:0]   wr_ch;
   logic [CNT_W-1:0]  wr_data;
   logic [NUM_CH-1:0] irq_ack;
   logic [CH_W-1:0]   rd_ch;
   logic [CNT_W-1:0]  rd_count;
   logic [NUM_CH-1:0] irq_pending;
   logic              irq;

   modport master (
      output wr_en, wr_sel, wr_ch, wr_data, irq_ack, rd_ch,
      input  rd_count, irq_pending, irq
   );

   modport slave (
      input  wr_en, wr_sel, wr_ch, wr_data, irq_ack, rd_ch,
      output rd_count, irq_pending, irq
   );
endinterface

// File: rtl/multi_pit.sv
// Multi-channel programmable interval timer: shared prescaler, per-channel
// one-shot/periodic down-counters, sticky interrupts with acknowledge.
module multi_pit #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned PRE_W  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   multi_pit_if.slave bus
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [1:0] SEL_RELOAD = 2'd0;
   localparam logic [1:0] SEL_CTRL   = 2'd1;
   localparam logic [1:0] SEL_PRE    = 2'd2;

   logic [PRE_W-1:0]  prescale_q, prescale_d;
   logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
   logic              tick_c;
   logic              pre_wr_c;

   logic [CNT_W-1:0]  reload_q [NUM_CH];
   logic [CNT_W-1:0]  reload_d [NUM_CH];
   logic [CNT_W-1:0]  count_q  [NUM_CH];
   logic [CNT_W-1:0]  count_d  [NUM_CH];
   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] per_q, per_d;
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic              irq_q, irq_d;

   // Shared prescaler; a divisor write restarts the phase and suppresses that cycle's tick
   always_comb begin
      pre_wr_c   = bus.wr_en && (bus.wr_sel == SEL_PRE);
      tick_c     = 1'b0;
      prescale_d = prescale_q;
      pre_cnt_d  = pre_cnt_q;
      if (pre_wr_c) begin
         prescale_d = PRE_W'(bus.wr_data);
         pre_cnt_d  = '0;
      end else if (pre_cnt_q == prescale_q) begin
         tick_c    = 1'b1;
         pre_cnt_d = '0;
      end else begin
         pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
   end

   // Channel counters: expiry is judged on pre-write state, then a control write overrides count/enable
   always_comb begin
      reload_d = reload_q;
      count_d  = count_q;
      en_d     = en_q;
      per_d    = per_q;
      pend_d   = pend_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (tick_c && en_q[i]) begin
            if (count_q[i] != '0) begin
               count_d[i] = count_q[i] - CNT_W'(1);
            end else if (per_q[i]) begin
               count_d[i] = reload_q[i];
            end else begin
               en_d[i] = 1'b0;
            end
         end

         if (tick_c && en_q[i] && (count_q[i] == '0)) begin
            pend_d[i] = 1'b1;
         end else if (bus.irq_ack[i]) begin
            pend_d[i] = 1'b0;
         end

         if (bus.wr_en && (bus.wr_ch == CH_W'(i))) begin
            if (bus.wr_sel == SEL_RELOAD) begin
               reload_d[i] = bus.wr_data;
            end else if (bus.wr_sel == SEL_CTRL) begin
               if (bus.wr_data[0]) begin
                  en_d[i]    = 1'b1;
                  per_d[i]   = bus.wr_data[1];
                  count_d[i] = reload_q[i];
               end else begin
                  en_d[i]    = 1'b0;
                  count_d[i] = count_q[i];
               end
            end
         end
      end
      irq_d = |pend_d;
   end

   // Readback mux; an out-of-range select reads zero
   always_comb begin
      bus.rd_count = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (bus.rd_ch == CH_W'(i)) begin
            bus.rd_count = count_q[i];
         end
      end
   end

   assign bus.irq_pending = pend_q;
   assign bus.irq         = irq_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescale_q <= '0;
         pre_cnt_q  <= '0;
         en_q       <= '0;
         per_q      <= '0;
         pend_q     <= '0;
         irq_q      <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            reload_q[i] <= '0;
            count_q[i]  <= '0;
         end
      end else begin
         prescale_q <= prescale_d;
         pre_cnt_q  <= pre_cnt_d;
         en_q       <= en_d;
         per_q      <= per_d;
         pend_q     <= pend_d;
         irq_q      <= irq_d;
         reload_q   <= reload_d;
         count_q    <= count_d;
      end
   end
endmodule

// File: tb/tb_multi_pit.sv
// Bench for multi_pit: expected interrupt rise cycles are queued when timers are
// programmed and matched when the DUT raises irq_pending; direct checks cover the rest.
module tb_multi_pit;
   localparam logic [1:0] SEL_RL  = 2'd0;
   localparam logic [1:0] SEL_CT  = 2'd1;
   localparam logic [1:0] SEL_PR  = 2'd2;
   localparam logic [1:0] SEL_RSV = 2'd3;

   typedef struct {
      int cyc;
      int ch;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   ev_t  sb_q[$];

   logic [3:0] man_ack = '0;
   logic [3:0] auto_ack = '0;
   logic [3:0] auto_mask = '0;
   logic [3:0] ack_chk = '0;
   logic [3:0] prev_pend = '0;
   logic [3:0] mon_rise;
   int         mon_idx;

   multi_pit_if #(.NUM_CH(4), .CNT_W(16)) bus ();
   multi_pit_if #(.NUM_CH(3), .CNT_W(16)) bus3 ();

   multi_pit #(.NUM_CH(4), .CNT_W(16), .PRE_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   multi_pit #(.NUM_CH(3), .CNT_W(16), .PRE_W(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3)
   );

   assign bus.irq_ack = man_ack | auto_ack;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int ch, input int c);
      ev_t e;
      e.ch  = ch;
      e.cyc = c;
      sb_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic wr(input logic [1:0] sel, input int ch, input int data, output int wcyc);
      wcyc         = cyc;
      bus.wr_en    = 1'b1;
      bus.wr_sel   = sel;
      bus.wr_ch    = 2'(ch);
      bus.wr_data  = 16'(data);
      step(1);
      bus.wr_en    = 1'b0;
      bus.wr_sel   = '0;
      bus.wr_data  = '0;
   endtask

   task automatic wr3(input logic [1:0] sel, input int ch, input int data, output int wcyc);
      wcyc         = cyc;
      bus3.wr_en   = 1'b1;
      bus3.wr_sel  = sel;
      bus3.wr_ch   = 2'(ch);
      bus3.wr_data = 16'(data);
      step(1);
      bus3.wr_en   = 1'b0;
      bus3.wr_sel  = '0;
      bus3.wr_data = '0;
   endtask

   // Rise monitor: match each new pending bit against the queue, auto-ack selected channels
   always @(negedge clk) begin
      if (!rst_n) begin
         auto_ack  = '0;
         ack_chk   = '0;
         prev_pend = bus.irq_pending;
      end else begin
         mon_rise = bus.irq_pending & ~prev_pend;
         for (int c = 0; c < 4; c++) begin
            if (ack_chk[c]) check($sformatf("ack_clear_ch%0d", c), 32'(bus.irq_pending[c]), 32'd0);
            if (mon_rise[c]) begin
               mon_idx = -1;
               for (int k = 0; k < sb_q.size(); k++)
                  if (mon_idx < 0 && sb_q[k].ch == c) mon_idx = k;
               if (mon_idx < 0) begin
                  check($sformatf("unexpected_fire_ch%0d", c), 32'(bus.irq_pending[c]), 32'd0);
               end else begin
                  check($sformatf("fire_cycle_ch%0d", c), 32'(cyc), 32'(sb_q[mon_idx].cyc));
                  sb_q.delete(mon_idx);
               end
            end
         end
         ack_chk   = mon_rise & auto_mask;
         auto_ack  = mon_rise & auto_mask;
         prev_pend = bus.irq_pending;
      end
   end

   initial begin
      int n, w, d, t2;
      bus.wr_en = 1'b0;  bus.wr_sel = '0;  bus.wr_ch = '0;  bus.wr_data = '0;  bus.rd_ch = '0;
      bus3.wr_en = 1'b0; bus3.wr_sel = '0; bus3.wr_ch = '0; bus3.wr_data = '0; bus3.rd_ch = '0;
      bus3.irq_ack = '0;

      // Reset held two cycles
      rst_n = 1'b0;
      step(2);
      check("rst_irq", 32'(bus.irq), 32'd0);
      check("rst_pending", 32'(bus.irq_pending), 32'd0);
      for (int c = 0; c < 4; c++) begin
         bus.rd_ch = 2'(c);
         #1;
         check($sformatf("rst_count_ch%0d", c), 32'(bus.rd_count), 32'd0);
      end
      rst_n = 1'b1;
      step(1);

      // One-shot ch0, reload 3
      auto_mask = 4'b1111;
      bus.rd_ch = 2'd0;
      wr(SEL_RL, 0, 3, d);
      wr(SEL_CT, 0, 1, n);
      push(0, n + 5);
      check("os_count_n1", 32'(bus.rd_count), 32'd3);
      step(1);
      check("os_count_n2", 32'(bus.rd_count), 32'd2);
      wait_until(n + 4);
      check("os_irq_before", 32'(bus.irq), 32'd0);
      step(1);
      check("os_irq", 32'(bus.irq), 32'd1);
      check("os_pending", 32'(bus.irq_pending), 32'h1);
      wait_until(n + 25);
      check("os_count_end", 32'(bus.rd_count), 32'd0);
      check("os_sb_empty", 32'(sb_q.size()), 32'd0);

      // Periodic ch1, reload 2, acked every fire; disable holds count
      wr(SEL_RL, 1, 2, d);
      wr(SEL_CT, 1, 3, n);
      for (int k = 0; k < 4; k++) push(1, n + 4 + 3 * k);
      wait_until(n + 14);
      wr(SEL_CT, 1, 0, d);
      bus.rd_ch = 2'd1;
      #1;
      check("dis_hold_a", 32'(bus.rd_count), 32'd1);
      step(3);
      check("dis_hold_b", 32'(bus.rd_count), 32'd1);
      check("per_sb_empty", 32'(sb_q.size()), 32'd0);

      // Prescale 4 (upper data bits ignored), ch2 reload 1 periodic
      wr(SEL_PR, 0, 32'h0104, w);
      wr(SEL_RL, 2, 1, d);
      wr(SEL_CT, 2, 3, n);
      t2 = w + 5 * ((n - w) / 5 + 1) + 5;
      for (int k = 0; k < 3; k++) push(2, t2 + 1 + 10 * k);
      wait_until(t2 + 22);
      wr(SEL_CT, 2, 0, d);
      wr(SEL_PR, 0, 0, d);
      step(12);
      check("pre_sb_empty", 32'(sb_q.size()), 32'd0);

      // Ack coinciding with re-expiry keeps pending; disable keeps pending
      auto_mask = 4'b1110;
      wr(SEL_RL, 0, 2, d);
      wr(SEL_CT, 0, 3, n);
      push(0, n + 4);
      wait_until(n + 6);
      man_ack = 4'b0001;
      step(1);
      man_ack = '0;
      check("ack_vs_set", 32'(bus.irq_pending[0]), 32'd1);
      man_ack = 4'b0001;
      push(0, n + 10);
      step(1);
      man_ack = '0;
      check("ack_clears", 32'(bus.irq_pending[0]), 32'd0);
      wait_until(n + 11);
      wr(SEL_CT, 0, 0, d);
      check("dis_keeps_pend", 32'(bus.irq_pending[0]), 32'd1);
      man_ack = 4'b0001;
      step(1);
      man_ack = '0;
      check("man_ack_clear", 32'(bus.irq_pending[0]), 32'd0);
      step(4);
      check("ack_sb_empty", 32'(sb_q.size()), 32'd0);

      // Mid-run reload change 5 -> 9 on ch3
      auto_mask = 4'b1111;
      wr(SEL_RL, 3, 5, d);
      wr(SEL_CT, 3, 3, n);
      push(3, n + 7);
      push(3, n + 17);
      push(3, n + 27);
      wait_until(n + 3);
      wr(SEL_RL, 3, 9, d);
      wait_until(n + 28);
      wr(SEL_CT, 3, 0, d);
      step(12);
      check("rl_sb_empty", 32'(sb_q.size()), 32'd0);

      // All channels running, reset pulsed mid-count
      for (int c = 0; c < 4; c++) wr(SEL_RL, c, 10 + c, d);
      for (int c = 0; c < 4; c++) wr(SEL_CT, c, 3, d);
      step(3);
      sb_q.delete();
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      check("mid_rst_irq", 32'(bus.irq), 32'd0);
      check("mid_rst_pending", 32'(bus.irq_pending), 32'd0);
      for (int c = 0; c < 4; c++) begin
         bus.rd_ch = 2'(c);
         #1;
         check($sformatf("mid_rst_count_ch%0d", c), 32'(bus.rd_count), 32'd0);
      end
      step(40);
      check("post_rst_irq", 32'(bus.irq), 32'd0);
      check("post_rst_count", 32'(bus.rd_count), 32'd0);

      // Three-channel build: writes to channel 3 and selector 3 are ignored
      for (int c = 0; c < 3; c++) wr3(SEL_RL, c, 7, d);
      wr3(SEL_CT, 3, 1, d);
      wr3(SEL_RL, 3, 5, d);
      wr3(SEL_RSV, 0, 3, d);
      step(3);
      for (int c = 0; c < 4; c++) begin
         bus3.rd_ch = 2'(c);
         #1;
         check($sformatf("ign_count_ch%0d", c), 32'(bus3.rd_count), 32'd0);
      end
      check("ign_pending", 32'(bus3.irq_pending), 32'd0);
      bus3.rd_ch = 2'd2;
      wr3(SEL_CT, 2, 1, n);
      check("ch3b_count", 32'(bus3.rd_count), 32'd7);
      wait_until(n + 8);
      check("ch3b_irq_before", 32'(bus3.irq), 32'd0);
      step(1);
      check("ch3b_pending", 32'(bus3.irq_pending), 32'h4);
      check("ch3b_irq", 32'(bus3.irq), 32'd1);

      check("final_sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
